// File: rtl/final_bits_sequencer.sv
// ---------------------------------------------------------------------------
// final_bits_sequencer
//
// Purpose:
//   Sequences the end-of-frame final-bits flush of the entropy encoder. An
//   accepted start latches the final cnt/low and enables the external
//   combinational final-bits generator for one evaluation cycle. The
//   generator's word-count flag and words are captured, then 0, 1 or 2
//   bitstream words are handed to the output packer over valid/ready, and
//   done pulses once the flush is complete. Sits between encoder stage 4 and
//   the bitstream packer. Every output is driven straight from a flop.
//
// Ports:
//   clk            in   rising-edge clock
//   reset          in   asynchronous, active-low reset
//   start          in   one-cycle flush request, honoured only when idle
//   abort          in   synchronous abort, back to idle on the next edge
//   in_cnt         in   final cnt, sampled on an accepted start
//   in_low         in   final low, sampled on an accepted start
//   gen_cnt        out  registered cnt feeding the generator
//   gen_low        out  registered low feeding the generator
//   gen_flag_final out  generator enable / operand isolation, high in EVAL
//   gen_flag       in   generator word count: 00 none, 01 one, 10 two
//   gen_bit_1      in   generator first word
//   gen_bit_2      in   generator second word
//   out_valid      out  word available on out_data
//   out_ready      in   packer accepts the word when out_valid & out_ready
//   out_data       out  emitted word
//   out_last       out  marks out_data as the final word of the flush
//   busy           out  high in every state except IDLE
//   done           out  one-cycle pulse when the flush completes
//   err            out  sticky illegal-flag (11) indicator
// ---------------------------------------------------------------------------
module final_bits_sequencer #(
  parameter int OUTPUT_BITSTREAM_WIDTH = 16,
  parameter int D_SIZE                 = 5,
  parameter int LOW_WIDTH              = 24
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic                              abort,
  input  logic [D_SIZE-1:0]                 in_cnt,
  input  logic [LOW_WIDTH-1:0]              in_low,
  output logic [D_SIZE-1:0]                 gen_cnt,
  output logic [LOW_WIDTH-1:0]              gen_low,
  output logic                              gen_flag_final,
  input  logic [1:0]                        gen_flag,
  input  logic [OUTPUT_BITSTREAM_WIDTH-1:0] gen_bit_1,
  input  logic [OUTPUT_BITSTREAM_WIDTH-1:0] gen_bit_2,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [OUTPUT_BITSTREAM_WIDTH-1:0] out_data,
  output logic                              out_last,
  output logic                              busy,
  output logic                              done,
  output logic                              err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_EVAL  = 3'd1,
    S_EMIT1 = 3'd2,
    S_EMIT2 = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                            state_q;
  // Number of words this flush emits (0, 1 or 2), taken from gen_flag.
  logic [1:0]                        nwords_q;
  // Second generator word, held until EMIT1 hands off. The first word is
  // captured directly into the out_data register.
  logic [OUTPUT_BITSTREAM_WIDTH-1:0] word2_q;

  // Single state machine; every output is assigned on the transition into
  // the state that needs it, so outputs are pure flops with no input paths.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      nwords_q       <= 2'd0;
      word2_q        <= '0;
      gen_cnt        <= '0;
      gen_low        <= '0;
      gen_flag_final <= 1'b0;
      out_valid      <= 1'b0;
      out_data       <= '0;
      out_last       <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
    end else begin
      done <= 1'b0;

      // Abort beats everything, including a start in IDLE. A handshake in
      // the abort cycle is already complete on the packer side.
      if (abort) begin
        state_q        <= S_IDLE;
        out_valid      <= 1'b0;
        out_last       <= 1'b0;
        gen_flag_final <= 1'b0;
        busy           <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start) begin
              gen_cnt        <= in_cnt;
              gen_low        <= in_low;
              err            <= 1'b0;
              gen_flag_final <= 1'b1;
              busy           <= 1'b1;
              state_q        <= S_EVAL;
            end
          end

          S_EVAL: begin
            gen_flag_final <= 1'b0;
            out_data       <= gen_bit_1;
            word2_q        <= gen_bit_2;
            case (gen_flag)
              2'b01: begin
                nwords_q  <= 2'd1;
                out_valid <= 1'b1;
                out_last  <= 1'b1;
                state_q   <= S_EMIT1;
              end
              2'b10: begin
                nwords_q  <= 2'd2;
                out_valid <= 1'b1;
                out_last  <= 1'b0;
                state_q   <= S_EMIT1;
              end
              2'b00: begin
                nwords_q <= 2'd0;
                done     <= 1'b1;
                state_q  <= S_DONE;
              end
              default: begin
                // Illegal flag: flush ends with no words and err latched.
                nwords_q <= 2'd0;
                err      <= 1'b1;
                done     <= 1'b1;
                state_q  <= S_DONE;
              end
            endcase
          end

          S_EMIT1: begin
            if (out_ready) begin
              if (nwords_q == 2'd2) begin
                // Swap in word 2 on the handshake edge: no bubble.
                out_data <= word2_q;
                out_last <= 1'b1;
                state_q  <= S_EMIT2;
              end else begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
                done      <= 1'b1;
                state_q   <= S_DONE;
              end
            end
          end

          S_EMIT2: begin
            if (out_ready) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              done      <= 1'b1;
              state_q   <= S_DONE;
            end
          end

          S_DONE: begin
            busy    <= 1'b0;
            state_q <= S_IDLE;
          end

          default: begin
            out_valid      <= 1'b0;
            out_last       <= 1'b0;
            gen_flag_final <= 1'b0;
            busy           <= 1'b0;
            state_q        <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_final_bits_sequencer.sv
// ---------------------------------------------------------------------------
// tb_final_bits_sequencer
//
// Directed bench for final_bits_sequencer. The generator is stubbed by
// driving gen_flag/gen_bit_1/gen_bit_2 directly. Inputs change and outputs
// are sampled 1 ns after each rising edge.
// ---------------------------------------------------------------------------
module tb_final_bits_sequencer;

  localparam int W  = 16;
  localparam int DS = 5;
  localparam int LW = 24;

  logic          clk;
  logic          reset;
  logic          start;
  logic          abort;
  logic [DS-1:0] in_cnt;
  logic [LW-1:0] in_low;
  logic [DS-1:0] gen_cnt;
  logic [LW-1:0] gen_low;
  logic          gen_flag_final;
  logic [1:0]    gen_flag;
  logic [W-1:0]  gen_bit_1;
  logic [W-1:0]  gen_bit_2;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          out_last;
  logic          busy;
  logic          done;
  logic          err;

  int total;
  int bad;

  final_bits_sequencer #(
    .OUTPUT_BITSTREAM_WIDTH(W),
    .D_SIZE(DS),
    .LOW_WIDTH(LW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .abort(abort),
    .in_cnt(in_cnt),
    .in_low(in_low),
    .gen_cnt(gen_cnt),
    .gen_low(gen_low),
    .gen_flag_final(gen_flag_final),
    .gen_flag(gen_flag),
    .gen_bit_1(gen_bit_1),
    .gen_bit_2(gen_bit_2),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_last(out_last),
    .busy(busy),
    .done(done),
    .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; stimulus and sampling both happen 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    in_cnt = '0; in_low = '0; gen_flag = 2'b00; gen_bit_1 = '0; gen_bit_2 = '0;
    step(); step();
    total++;
    if ({out_valid, out_last, busy, done, err, gen_flag_final} !== 6'b0) begin
      bad++;
      $display("[TB] FAIL reset_ctrl: got %b want 000000",
               {out_valid, out_last, busy, done, err, gen_flag_final});
    end
    total++;
    if ({out_data, gen_cnt, gen_low} !== '0) begin
      bad++;
      $display("[TB] FAIL reset_data: out_data=%h gen_cnt=%h gen_low=%h want 0",
               out_data, gen_cnt, gen_low);
    end
    reset = 1'b1;
    step();
  endtask

  task automatic test_one_word();
    gen_flag = 2'b01; gen_bit_1 = 16'h1234; gen_bit_2 = 16'hFFFF; out_ready = 1'b1;
    start = 1'b1; in_cnt = 5'd5; in_low = 24'h00ABCD;
    step();                                    // N+1: EVAL
    start = 1'b0;
    total++;
    if ({gen_flag_final, busy, out_valid, gen_cnt, gen_low} !== {1'b1, 1'b1, 1'b0, 5'd5, 24'h00ABCD}) begin
      bad++;
      $display("[TB] FAIL one_eval: flagf=%b busy=%b valid=%b cnt=%0d low=%h want 1 1 0 5 00abcd",
               gen_flag_final, busy, out_valid, gen_cnt, gen_low);
    end
    step();                                    // N+2: EMIT1
    total++;
    if ({gen_flag_final, out_valid, out_last, done, out_data} !== {1'b0, 1'b1, 1'b1, 1'b0, 16'h1234}) begin
      bad++;
      $display("[TB] FAIL one_emit: flagf=%b valid=%b last=%b done=%b data=%h want 0 1 1 0 1234",
               gen_flag_final, out_valid, out_last, done, out_data);
    end
    step();                                    // N+3: DONE
    total++;
    if ({done, busy, out_valid} !== 3'b110) begin
      bad++;
      $display("[TB] FAIL one_done: done=%b busy=%b valid=%b want 1 1 0", done, busy, out_valid);
    end
    step();                                    // N+4: IDLE
    total++;
    if ({done, busy} !== 2'b00) begin
      bad++;
      $display("[TB] FAIL one_idle: done=%b busy=%b want 0 0", done, busy);
    end
  endtask

  task automatic test_two_words();
    gen_flag = 2'b10; gen_bit_1 = 16'hAAAA; gen_bit_2 = 16'h5555; out_ready = 1'b1;
    start = 1'b1; in_cnt = 5'd17; in_low = 24'h123456;
    step();
    start = 1'b0;
    step();
    total++;
    if ({out_valid, out_last, out_data} !== {1'b1, 1'b0, 16'hAAAA}) begin
      bad++;
      $display("[TB] FAIL two_w1: valid=%b last=%b data=%h want 1 0 aaaa", out_valid, out_last, out_data);
    end
    step();
    total++;
    if ({out_valid, out_last, out_data, done} !== {1'b1, 1'b1, 16'h5555, 1'b0}) begin
      bad++;
      $display("[TB] FAIL two_w2: valid=%b last=%b data=%h done=%b want 1 1 5555 0",
               out_valid, out_last, out_data, done);
    end
    step();
    total++;
    if ({done, out_valid} !== 2'b10) begin
      bad++;
      $display("[TB] FAIL two_done: done=%b valid=%b want 1 0", done, out_valid);
    end
    step();
  endtask

  task automatic test_backpressure();
    gen_flag = 2'b10; gen_bit_1 = 16'hAAAA; gen_bit_2 = 16'h5555; out_ready = 1'b0;
    start = 1'b1; in_cnt = 5'd3; in_low = 24'h000001;
    step();
    start = 1'b0;
    step();                                    // first EMIT1 cycle
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({out_valid, out_last, out_data, busy} !== {1'b1, 1'b0, 16'hAAAA, 1'b1}) begin
        bad++;
        $display("[TB] FAIL bp_hold%0d: valid=%b last=%b data=%h busy=%b want 1 0 aaaa 1",
                 i, out_valid, out_last, out_data, busy);
      end
      step();
    end
    total++;
    if ({out_valid, out_data} !== {1'b1, 16'hAAAA}) begin
      bad++;
      $display("[TB] FAIL bp_hold3: valid=%b data=%h want 1 aaaa", out_valid, out_data);
    end
    out_ready = 1'b1;
    step();
    total++;
    if ({out_valid, out_last, out_data} !== {1'b1, 1'b1, 16'h5555}) begin
      bad++;
      $display("[TB] FAIL bp_w2: valid=%b last=%b data=%h want 1 1 5555", out_valid, out_last, out_data);
    end
    step();
    total++;
    if (done !== 1'b1) begin
      bad++;
      $display("[TB] FAIL bp_done: done=%b want 1", done);
    end
    step();
  endtask

  task automatic test_zero_and_err();
    gen_flag = 2'b00; out_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    total++;
    if ({gen_flag_final, out_valid} !== 2'b10) begin
      bad++;
      $display("[TB] FAIL zero_eval: flagf=%b valid=%b want 1 0", gen_flag_final, out_valid);
    end
    step();                                    // N+2: done
    total++;
    if ({done, out_valid, busy, err} !== 4'b1010) begin
      bad++;
      $display("[TB] FAIL zero_done: done=%b valid=%b busy=%b err=%b want 1 0 1 0", done, out_valid, busy, err);
    end
    step();
    gen_flag = 2'b11;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    total++;
    if ({err, done, out_valid} !== 3'b110) begin
      bad++;
      $display("[TB] FAIL err_done: err=%b done=%b valid=%b want 1 1 0", err, done, out_valid);
    end
    step(); step();
    total++;
    if ({err, busy, out_valid} !== 3'b100) begin
      bad++;
      $display("[TB] FAIL err_sticky: err=%b busy=%b valid=%b want 1 0 0", err, busy, out_valid);
    end
    gen_flag = 2'b01; gen_bit_1 = 16'h0F0F;
    start = 1'b1;
    step();
    start = 1'b0;
    total++;
    if ({err, gen_flag_final} !== 2'b01) begin
      bad++;
      $display("[TB] FAIL err_clear: err=%b flagf=%b want 0 1", err, gen_flag_final);
    end
    step(); step(); step();
  endtask

  task automatic test_start_abort();
    // start and abort together in IDLE: nothing starts
    start = 1'b1; abort = 1'b1; in_cnt = 5'd30;
    step();
    start = 1'b0; abort = 1'b0;
    total++;
    if ({busy, gen_flag_final, gen_cnt == 5'd30} !== 3'b000) begin
      bad++;
      $display("[TB] FAIL idle_abort: busy=%b flagf=%b gen_cnt=%0d want 0 0 !=30", busy, gen_flag_final, gen_cnt);
    end
    gen_flag = 2'b10; gen_bit_1 = 16'hAAAA; gen_bit_2 = 16'h5555; out_ready = 1'b1;
    start = 1'b1; in_cnt = 5'd7; in_low = 24'h0000AA;
    step();
    start = 1'b0;
    step();                                    // EMIT1, handshake at next edge
    start = 1'b1; in_cnt = 5'd9; in_low = 24'h111111;
    step();                                    // EMIT2
    start = 1'b0; out_ready = 1'b0;
    total++;
    if ({out_valid, out_data, gen_cnt, gen_low} !== {1'b1, 16'h5555, 5'd7, 24'h0000AA}) begin
      bad++;
      $display("[TB] FAIL busy_start: valid=%b data=%h cnt=%0d low=%h want 1 5555 7 0000aa",
               out_valid, out_data, gen_cnt, gen_low);
    end
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    total++;
    if ({out_valid, out_last, busy, done, gen_flag_final} !== 5'b0) begin
      bad++;
      $display("[TB] FAIL abort_idle: valid=%b last=%b busy=%b done=%b flagf=%b want 0",
               out_valid, out_last, busy, done, gen_flag_final);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if ({done, busy, gen_flag_final} !== 3'b000) begin
        bad++;
        $display("[TB] FAIL abort_quiet%0d: done=%b busy=%b flagf=%b want 0 0 0", i, done, busy, gen_flag_final);
      end
    end
  endtask

  task automatic test_async_reset();
    gen_flag = 2'b01; gen_bit_1 = 16'hBEEF; out_ready = 1'b0;
    start = 1'b1; in_cnt = 5'd11; in_low = 24'hC0FFEE;
    step();
    start = 1'b0;
    step();
    total++;
    if ({out_valid, out_data} !== {1'b1, 16'hBEEF}) begin
      bad++;
      $display("[TB] FAIL ar_pre: valid=%b data=%h want 1 beef", out_valid, out_data);
    end
    #2 reset = 1'b0;
    #1;
    total++;
    if ({out_valid, out_last, busy, done, err, gen_flag_final, out_data, gen_cnt, gen_low} !== '0) begin
      bad++;
      $display("[TB] FAIL ar_zero: valid=%b busy=%b data=%h cnt=%0d low=%h want all 0",
               out_valid, busy, out_data, gen_cnt, gen_low);
    end
    step();
    reset = 1'b1; out_ready = 1'b1;
    step();
    gen_bit_1 = 16'h1234;
    start = 1'b1; in_cnt = 5'd5; in_low = 24'h00ABCD;
    step();
    start = 1'b0;
    total++;
    if ({gen_flag_final, gen_cnt} !== {1'b1, 5'd5}) begin
      bad++;
      $display("[TB] FAIL ar_eval: flagf=%b cnt=%0d want 1 5", gen_flag_final, gen_cnt);
    end
    step();
    total++;
    if ({out_valid, out_last, out_data} !== {1'b1, 1'b1, 16'h1234}) begin
      bad++;
      $display("[TB] FAIL ar_emit: valid=%b last=%b data=%h want 1 1 1234", out_valid, out_last, out_data);
    end
    step();
    total++;
    if (done !== 1'b1) begin
      bad++;
      $display("[TB] FAIL ar_done: done=%b want 1", done);
    end
    step();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_one_word();
    test_two_words();
    test_backpressure();
    test_zero_and_err();
    test_start_abort();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/final_bits_sequencer.md
Name: final_bits_sequencer

Overview:
- Controller that sequences the end-of-frame final-bits generation, i.e. the start of OD_EC_ENC_DONE.
- On a start pulse it latches the final cnt/low and enables the combinational final-bits generator (operand-isolated) for exactly one evaluation cycle. It then captures the generator's flag and words.
- It emits 0, 1 or 2 bitstream words over a valid/ready handshake, then pulses done.
- Sits between stage 4 of the encoder pipeline and the output bitstream packer.

Parameters:
- OUTPUT_BITSTREAM_WIDTH, 16, width of each emitted word and of the generator words
- D_SIZE, 5, width of the cnt value
- LOW_WIDTH, 24, width of the low register value

Ports:
- clk  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-low reset
- start  input  1  one-cycle request to run the final flush; ignored unless state is IDLE
- abort  input  1  synchronous abort; returns to IDLE next cycle from any state
- in_cnt  input  D_SIZE  final cnt, sampled on accepted start
- in_low  input  LOW_WIDTH  final low, sampled on accepted start
- gen_cnt  output  D_SIZE  cnt driven to the generator (registered copy)
- gen_low  output  LOW_WIDTH  low driven to the generator (registered copy)
- gen_flag_final  output  1  generator enable / operand-isolation control; 1 only in EVAL
- gen_flag  input  2  generator word-count flag: 00 none, 01 one word, 10 two words
- gen_bit_1  input  OUTPUT_BITSTREAM_WIDTH  generator first word
- gen_bit_2  input  OUTPUT_BITSTREAM_WIDTH  generator second word
- out_valid  output  1  word available on out_data
- out_ready  input  1  downstream accepts the word when out_valid & out_ready
- out_data  output  OUTPUT_BITSTREAM_WIDTH  emitted word
- out_last  output  1  qualifies out_data as the final word of the flush
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse when the flush completes
- err  output  1  sticky: illegal gen_flag (11) seen; cleared by an accepted start or by reset

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE. All outputs 0: out_valid, out_data, out_last, busy, done, err, gen_flag_final, gen_cnt, gen_low. Internal word registers and word count are also 0.
- All outputs are registered. Combinational input to output paths are not permitted.
- States: IDLE, EVAL, EMIT1, EMIT2, DONE. Encoding is free.
- IDLE:
  - On start=1: latch in_cnt into gen_cnt and in_low into gen_low, clear err, go to EVAL.
  - gen_cnt and gen_low hold their value outside an accepted start.
- EVAL (exactly 1 cycle):
  - gen_flag_final=1.
  - At the end of the cycle, capture gen_bit_1, gen_bit_2 and gen_flag into internal registers.
  - Transition on gen_flag:
    - 00: go to DONE.
    - 01: nwords=1, go to EMIT1.
    - 10: nwords=2, go to EMIT1.
    - 11: set err, go to DONE with no words emitted.
- EMIT1:
  - out_valid=1, out_data=captured word1, out_last=(nwords==1).
  - Hold out_valid and out_data stable until the handshake.
  - On handshake: go to EMIT2 if nwords==2, else go to DONE.
- EMIT2:
  - out_valid=1, out_data=captured word2, out_last=1.
  - On handshake: go to DONE.
- DONE (1 cycle): done=1, busy=1, then go to IDLE.
- gen_flag_final=0 in every state except EVAL. Generator outputs are don't-care outside EVAL.
- Latency:
  - Accepted start at cycle N gives EVAL at N+1.
  - First out_valid at N+2.
  - done asserts 1 cycle after the last handshake.
  - Zero-word flush: done at N+2.
- out_ready is ignored when out_valid=0. out_ready held high gives one word per cycle, with no bubble between EMIT1 and EMIT2.
- start while busy=1 is dropped; there is no queueing.
- start and abort together in IDLE: abort wins and start is dropped.
- abort in any non-IDLE state:
  - Next state is IDLE; out_valid, out_last and gen_flag_final are deasserted.
  - No done pulse.
  - A word whose handshake completes in the abort cycle counts as delivered.
- Reset mid-flush: immediate return to IDLE per the reset values; there is no partial-state retention.
- err stays set through IDLE until the next accepted start.

Test Plan:
- Reset, then start with in_cnt=5, in_low=0x00ABCD. Stub gen_flag=01, gen_bit_1=0x1234.
  - Required: gen_flag_final=1 for exactly 1 cycle.
  - Required: out_valid at N+2 with out_data=0x1234, out_last=1; done at N+3; busy low at N+4.
- gen_flag=10, gen_bit_1=0xAAAA, gen_bit_2=0x5555, out_ready=1 throughout.
  - Required: 0xAAAA (last=0), then 0x5555 (last=1) on consecutive cycles, then done.
- Same as the two-word case, but out_ready=0 for 3 cycles in EMIT1.
  - Required: out_data stays at 0xAAAA, out_valid stays high, and no state advance until ready.
- gen_flag=00: no out_valid ever; done at N+2. Then gen_flag=11: err=1, done pulses, no words. The next accepted start clears err.
- Start pulse asserted during EMIT1: ignored, with no second flush. Abort asserted during EMIT2 (out_ready=0): out_valid low the next cycle, state IDLE, done never pulses.
- Assert reset low asynchronously mid-EMIT1 (between clock edges): outputs are 0 immediately. After release, a fresh start runs a normal one-word flush.
